mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access and write-back staging block for the miniRISC pipeline. It takes one instruction at a time from the execute stage and runs the data-memory load/store handshake when the instruction needs one. It registers the three write-back candidates (ALU result, load data, link address) together with the 2-bit write-back select. Its outputs drive the 32-bit 3:1 write-back multiplexer directly.

## Interface
Parameters:
- DW, 32, data/address width
- RW, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  this block accepts the instruction this cycle
- ex_alu_result  in  DW  ALU result; also the memory address
- ex_store_data  in  DW  store data
- ex_link_addr  in  DW  return address (PC+4)
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_reg_write  in  1  instruction writes a register
- ex_wb_sel  in  2  write-back select: 00 ALU, 01 memory, 10 link
- ex_rd  in  RW  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DW  word address
- dmem_wdata  out  DW  store data
- dmem_ready  in  1  memory completes the request this cycle
- dmem_rdata  in  DW  load data, valid when dmem_ready = 1
- wb_valid  out  1  one-cycle commit pulse
- wb_reg_write  out  1  register-file write enable, gated by wb_valid
- wb_rd  out  RW  destination register
- wb_sel  out  2  select for the write-back mux
- wb_alu, wb_mem, wb_link  out  DW each  mux inputs in0, in1, in2
- wb_misalign  out  1  misaligned access flag (see Configuration)

## Operation
- The block is a two-state FSM: IDLE and ACCESS.
- **IDLE**
  - ex_ready = 1.
  - Handshake: the block accepts an instruction when ex_valid && ex_ready.
- **Accepting a non-memory instruction**
  - On the next edge, wb_alu, wb_link, wb_sel and wb_rd load from the execute inputs.
  - wb_valid and wb_reg_write (= ex_reg_write) assert for one cycle.
  - The FSM stays in IDLE.
- **Accepting a memory instruction** (load or store)
  - Latch the request: dmem_addr = {ex_alu_result[DW-1:2], 2'b00}, dmem_we = ex_mem_write, dmem_wdata = ex_store_data.
  - Latch the write-back fields as for a non-memory instruction.
  - Move to ACCESS.
  - If ex_mem_read and ex_mem_write are both set, treat the instruction as a store.
- **ACCESS**
  - dmem_req = 1 with addr, we and wdata held stable. ex_ready = 0.
  - Each cycle dmem_ready = 1:
    - for a load, capture dmem_rdata into wb_mem;
    - on the next edge, pulse wb_valid and return to IDLE.
  - The stall is unbounded while dmem_ready = 0.
- **Stores**
  - wb_reg_write is forced to 0, whatever ex_reg_write is.
  - wb_mem is unchanged.
- **Write-back select**
  - wb_sel passes through unchanged. Value 11 means link, consistent with the mux default.
- **Held values**
  - wb_* data and select outputs hold their last committed values between pulses.
  - wb_reg_write = 0 whenever wb_valid = 0.
- **Reset** (asynchronous, including mid-ACCESS)
  - FSM returns to IDLE and any in-flight transaction is abandoned.
  - Reset values: dmem_req, dmem_we, wb_valid, wb_reg_write, wb_misalign = 0; all data/address outputs, wb_rd and wb_sel = 0.
  - ex_ready = 1 while rst_n is low.

## Timing
- Non-memory instruction: accepted at edge N, committed (wb_valid = 1) in cycle N+1. Throughput is one per cycle with ex_ready held at 1.
- Memory instruction, zero-wait memory:
  - accepted at edge N;
  - dmem_req = 1 in cycle N+1, with dmem_ready = 1 in that cycle;
  - wb_valid = 1 and ex_ready = 1 in cycle N+2.
- Each wait cycle adds one cycle of latency.
- dmem_req deasserts in the cycle after dmem_ready is sampled high.
- ex_ready is a Moore output: 1 in IDLE, 0 in ACCESS. It has no combinational path from ex_valid.
- dmem_ready is ignored outside ACCESS.

## Configuration
- Macro: MEM_WB_MISALIGN_TRAP_EN.
- **Defined**
  - A memory instruction with ex_alu_result[1:0] != 00 is accepted but issues no dmem_req and stays in IDLE.
  - The next cycle pulses wb_valid with wb_misalign = 1 and wb_reg_write = 0.
  - wb_misalign is otherwise 0.
- **Undefined**
  - The low address bits are silently cleared (word access proceeds).
  - wb_misalign is tied to 0.

## Test plan
- Reset mid-ACCESS:
  - Stimulus: a load is waiting with dmem_ready = 0; pulse rst_n low.
  - Response: dmem_req drops immediately, FSM is in IDLE, ex_ready = 1, no wb_valid.
- ALU instruction:
  - Stimulus: ex_alu_result = 0x0000_0007, ex_wb_sel = 00, ex_rd = 5, ex_reg_write = 1.
  - Response: next cycle wb_valid = 1, wb_reg_write = 1, wb_alu = 0x7, wb_rd = 5, wb_sel = 00.
- Load with 2 wait states:
  - Stimulus: address 0x100; dmem_rdata = 0xDEAD_BEEF with dmem_ready high in the 3rd ACCESS cycle.
  - Response: dmem_req held high for 3 cycles with dmem_addr = 0x100 and ex_ready = 0; then wb_mem = 0xDEAD_BEEF, wb_sel = 01, wb_valid pulse.
- Store:
  - Stimulus: address 0x40, data 0x1234, ex_reg_write = 1, zero-wait memory.
  - Response: dmem_we = 1, dmem_wdata = 0x1234, wb_valid pulse with wb_reg_write = 0.
- Back-to-back:
  - Stimulus: three ALU instructions, then a JAL (wb_sel = 10, link = 0x2C).
  - Response: four consecutive wb_valid cycles, the last with wb_link = 0x2C.
- Misaligned load at address 0x102:
  - With the macro defined: no dmem_req, wb_misalign = 1, wb_reg_write = 0.
  - Without the macro: dmem_addr = 0x100.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back staging register for the miniRISC pipeline.
// Optional build macro MEM_WB_MISALIGN_TRAP_EN turns misaligned memory accesses into flagged commits.
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_store_data,
    input  logic [DW-1:0] ex_link_addr,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic          ex_reg_write,
    input  logic [1:0]    ex_wb_sel,
    input  logic [RW-1:0] ex_rd,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ready,
    input  logic [DW-1:0] dmem_rdata,
    output logic          wb_valid,
    output logic          wb_reg_write,
    output logic [RW-1:0] wb_rd,
    output logic [1:0]    wb_sel,
    output logic [DW-1:0] wb_alu,
    output logic [DW-1:0] wb_mem,
    output logic [DW-1:0] wb_link,
    output logic          wb_misalign
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic [DW-1:0] dmem_addr_q, dmem_addr_d;
    logic [DW-1:0] dmem_wdata_q, dmem_wdata_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_reg_write_q, wb_reg_write_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [1:0]    wb_sel_q, wb_sel_d;
    logic [DW-1:0] wb_alu_q, wb_alu_d;
    logic [DW-1:0] wb_mem_q, wb_mem_d;
    logic [DW-1:0] wb_link_q, wb_link_d;
    logic          pend_rw_q, pend_rw_d;

    logic accept;
    logic is_mem;
    logic is_store;
    logic misaligned;

    assign accept   = ex_valid && (state_q == S_IDLE);
    assign is_mem   = ex_mem_read || ex_mem_write;
    // A read+write encoding is resolved as a store.
    assign is_store = ex_mem_write;

`ifdef MEM_WB_MISALIGN_TRAP_EN
    logic wb_misalign_q, wb_misalign_d;
    assign misaligned  = is_mem && (ex_alu_result[1:0] != 2'b00);
    assign wb_misalign = wb_misalign_q;
`else
    assign misaligned  = 1'b0;
    assign wb_misalign = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_sel_d       = wb_sel_q;
        wb_alu_d       = wb_alu_q;
        wb_mem_d       = wb_mem_q;
        wb_link_d      = wb_link_q;
        pend_rw_d      = pend_rw_q;
`ifdef MEM_WB_MISALIGN_TRAP_EN
        wb_misalign_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wb_alu_d  = ex_alu_result;
                    wb_link_d = ex_link_addr;
                    wb_sel_d  = ex_wb_sel;
                    wb_rd_d   = ex_rd;
                    if (is_mem && !misaligned) begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {ex_alu_result[DW-1:2], 2'b00};
                        dmem_wdata_d = ex_store_data;
                        pend_rw_d    = ex_reg_write && !is_store;
                        state_d      = S_ACCESS;
                    end else begin
                        // Misaligned traps land here too and never write a register.
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = ex_reg_write && !is_mem;
`ifdef MEM_WB_MISALIGN_TRAP_EN
                        wb_misalign_d  = misaligned;
`endif
                    end
                end
            end
            S_ACCESS: begin
                if (dmem_ready) begin
                    dmem_req_d     = 1'b0;
                    dmem_we_d      = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = pend_rw_q;
                    if (!dmem_we_q) begin
                        wb_mem_d = dmem_rdata;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                dmem_req_d = 1'b0;
                dmem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_sel_q       <= '0;
            wb_alu_q       <= '0;
            wb_mem_q       <= '0;
            wb_link_q      <= '0;
            pend_rw_q      <= 1'b0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
            wb_misalign_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_sel_q       <= wb_sel_d;
            wb_alu_q       <= wb_alu_d;
            wb_mem_q       <= wb_mem_d;
            wb_link_q      <= wb_link_d;
            pend_rw_q      <= pend_rw_d;
`ifdef MEM_WB_MISALIGN_TRAP_EN
            wb_misalign_q  <= wb_misalign_d;
`endif
        end
    end

    // Moore handshake: no path from ex_valid, and 1 throughout reset.
    assign ex_ready     = (state_q == S_IDLE);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_sel       = wb_sel_q;
    assign wb_alu       = wb_alu_q;
    assign wb_mem       = wb_mem_q;
    assign wb_link      = wb_link_q;

endmodule
